// File: rtl/usr_seq_pkg.sv
// Shared codes for the universal shift register: sel/fill encodings, shift
// direction and sequencer state codes.
package usr_seq_pkg;

  localparam logic [1:0] SEL_HOLD = 2'b00;
  localparam logic [1:0] SEL_SHR  = 2'b01;
  localparam logic [1:0] SEL_SHL  = 2'b10;
  localparam logic [1:0] SEL_LOAD = 2'b11;

  localparam logic [1:0] FILL_SER   = 2'b00;
  localparam logic [1:0] FILL_ROT   = 2'b01;
  localparam logic [1:0] FILL_ARITH = 2'b10;
  localparam logic [1:0] FILL_ZERO  = 2'b11;

  localparam logic DIR_R = 1'b0;
  localparam logic DIR_L = 1'b1;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Direction implied by a sel code; only meaningful for SEL_SHR/SEL_SHL.
  function automatic logic sel_dir(input logic [1:0] sel);
    return (sel == SEL_SHL) ? DIR_L : DIR_R;
  endfunction

endpackage

// File: rtl/usr_shift_step.sv
// Combinational single-step shifter: one right or left shift of q with the
// selected fill bit. Optional USR_SEQ_CARRY_EN adds the bit_out port.
module usr_shift_step
  import usr_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  logic             dir,
  input  logic [1:0]       fill,
  input  logic             sin_right,
  input  logic             sin_left,
  output logic [WIDTH-1:0] q_next
`ifdef USR_SEQ_CARRY_EN
  , output logic           bit_out
`endif
);

  logic fill_bit;

  always_comb begin
    fill_bit = 1'b0;
    if (dir == DIR_R) begin
      case (fill)
        FILL_SER:   fill_bit = sin_right;
        FILL_ROT:   fill_bit = q[0];
        FILL_ARITH: fill_bit = q[WIDTH-1];
        default:    fill_bit = 1'b0;
      endcase
    end else begin
      // Arithmetic left shift fills with zero, same as FILL_ZERO.
      case (fill)
        FILL_SER: fill_bit = sin_left;
        FILL_ROT: fill_bit = q[WIDTH-1];
        default:  fill_bit = 1'b0;
      endcase
    end
  end

  always_comb begin
    if (dir == DIR_R) q_next = {fill_bit, q[WIDTH-1:1]};
    else              q_next = {q[WIDTH-2:0], fill_bit};
  end

`ifdef USR_SEQ_CARRY_EN
  assign bit_out = (dir == DIR_R) ? q[0] : q[WIDTH-1];
`endif

endmodule

// File: rtl/universal_shift_reg_seq.sv
// WIDTH-bit universal shift register with direct hold/shift/load and a
// multi-step shift sequencer. Optional carry output via USR_SEQ_CARRY_EN.
module universal_shift_reg_seq
  import usr_seq_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [1:0]       sel,
  input  logic [1:0]       fill,
  input  logic             sin_right,
  input  logic             sin_left,
  input  logic [WIDTH-1:0] par_in,
  input  logic             start,
  input  logic [CNT_W-1:0] amount,
  output logic [WIDTH-1:0] q,
  output logic             sout_right,
  output logic             sout_left,
  output logic             busy,
  output logic             done,
  output logic [0:0]       state_dbg
`ifdef USR_SEQ_CARRY_EN
  , output logic           carry
`endif
);

  localparam logic [0:0] S_IDLE  = ST_IDLE;
  localparam logic [0:0] S_SHIFT = ST_SHIFT;

  // Handshake: in IDLE, start with sel=SHR/SHL is taken on the clock edge it
  // is high. busy is high for exactly 'amount' cycles while shifting, and done
  // pulses one cycle when the last shift lands (or one cycle after a start with
  // amount=0). There is no ready; a start while busy is simply ignored.

  logic [0:0]       state, state_n;
  logic [CNT_W-1:0] remaining, remaining_n;
  logic             dir_q, dir_n;
  logic [1:0]       fill_q, fill_n;
  logic [WIDTH-1:0] q_n;
  logic             done_n;
  logic             step_dir;
  logic [1:0]       step_fill;
  logic [WIDTH-1:0] step_q;
  logic             shift_sel;
`ifdef USR_SEQ_CARRY_EN
  logic             step_bit;
  logic             carry_n;
`endif

  // Sequenced shifts use the latched controls; direct mode uses live inputs.
  always_comb begin
    step_dir  = sel_dir(sel);
    step_fill = fill;
    if (state == S_SHIFT) begin
      step_dir  = dir_q;
      step_fill = fill_q;
    end
  end

  usr_shift_step #(.WIDTH(WIDTH)) u_step (
    .q         (q),
    .dir       (step_dir),
    .fill      (step_fill),
    .sin_right (sin_right),
    .sin_left  (sin_left),
    .q_next    (step_q)
`ifdef USR_SEQ_CARRY_EN
    , .bit_out (step_bit)
`endif
  );

  assign shift_sel = (sel == SEL_SHR) || (sel == SEL_SHL);

  always_comb begin
    state_n     = state;
    remaining_n = remaining;
    dir_n       = dir_q;
    fill_n      = fill_q;
    q_n         = q;
    done_n      = 1'b0;
`ifdef USR_SEQ_CARRY_EN
    carry_n     = carry;
`endif
    case (state)
      S_IDLE: begin
        if (start && shift_sel) begin
          if (amount != '0) begin
            state_n     = S_SHIFT;
            remaining_n = amount;
            dir_n       = sel_dir(sel);
            fill_n      = fill;
          end else begin
            done_n = 1'b1;
          end
        end else begin
          case (sel)
            SEL_SHR, SEL_SHL: begin
              q_n = step_q;
`ifdef USR_SEQ_CARRY_EN
              carry_n = step_bit;
`endif
            end
            SEL_LOAD: q_n = par_in;
            default:  q_n = q;
          endcase
        end
      end
      S_SHIFT: begin
        q_n         = step_q;
        remaining_n = remaining - CNT_W'(1);
`ifdef USR_SEQ_CARRY_EN
        carry_n     = step_bit;
`endif
        if (remaining == CNT_W'(1)) begin
          state_n = S_IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state     <= S_IDLE;
      remaining <= '0;
      dir_q     <= DIR_R;
      fill_q    <= FILL_SER;
      q         <= '0;
      done      <= 1'b0;
`ifdef USR_SEQ_CARRY_EN
      carry     <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      remaining <= remaining_n;
      dir_q     <= dir_n;
      fill_q    <= fill_n;
      q         <= q_n;
      done      <= done_n;
`ifdef USR_SEQ_CARRY_EN
      carry     <= carry_n;
`endif
    end
  end

  assign busy       = (state == S_SHIFT);
  assign state_dbg  = state;
  assign sout_right = q[0];
  assign sout_left  = q[WIDTH-1];

endmodule

// File: tb/tb_universal_shift_reg_seq.sv
// Directed bench for universal_shift_reg_seq (WIDTH=8); carry checks are
// compiled in when USR_SEQ_CARRY_EN is defined.
module tb_universal_shift_reg_seq;

  localparam int WIDTH = 8;
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             clk = 1'b0;
  logic             clear;
  logic [1:0]       sel;
  logic [1:0]       fill;
  logic             sin_right;
  logic             sin_left;
  logic [WIDTH-1:0] par_in;
  logic             start;
  logic [CNT_W-1:0] amount;
  logic [WIDTH-1:0] q;
  logic             sout_right;
  logic             sout_left;
  logic             busy;
  logic             done;
  logic [0:0]       state_dbg;
`ifdef USR_SEQ_CARRY_EN
  logic             carry;
`endif

  int total = 0;
  int bad   = 0;
  logic [WIDTH-1:0] exp_q[$];

  universal_shift_reg_seq #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .clear      (clear),
    .sel        (sel),
    .fill       (fill),
    .sin_right  (sin_right),
    .sin_left   (sin_left),
    .par_in     (par_in),
    .start      (start),
    .amount     (amount),
    .q          (q),
    .sout_right (sout_right),
    .sout_left  (sout_left),
    .busy       (busy),
    .done       (done),
    .state_dbg  (state_dbg)
`ifdef USR_SEQ_CARRY_EN
    , .carry    (carry)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one active edge; outputs are then sampled 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_seq_q(input string tag);
    logic [WIDTH-1:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check(tag, {24'd0, q}, {24'd0, e});
    end
  endtask

  initial begin
    clear = 1'b0; sel = 2'b00; fill = 2'b00; sin_right = 1'b0; sin_left = 1'b0;
    par_in = '0; start = 1'b0; amount = '0;
    #12;
    check("rst_q", {24'd0, q}, 32'h00);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_state", {31'd0, state_dbg}, 32'd0);
`ifdef USR_SEQ_CARRY_EN
    check("rst_carry", {31'd0, carry}, 32'd0);
`endif
    #4 clear = 1'b1;
    step();

    // Direct mode
    sel = 2'b11; par_in = 8'h96; step();
    check("load_96", {24'd0, q}, 32'h96);
    check("sout_right_96", {31'd0, sout_right}, 32'd0);
    check("sout_left_96", {31'd0, sout_left}, 32'd1);
    sel = 2'b01; fill = 2'b00; sin_right = 1'b1; step();
    check("shr_serial", {24'd0, q}, 32'hCB);
    sel = 2'b10; fill = 2'b11; step();
    check("shl_zero", {24'd0, q}, 32'h96);
    sel = 2'b00; step();
    check("hold", {24'd0, q}, 32'h96);
    sel = 2'b01; fill = 2'b01; step();
    check("shr_rot", {24'd0, q}, 32'h4B);
    sel = 2'b10; fill = 2'b10; step();
    check("shl_arith", {24'd0, q}, 32'h96);
    sel = 2'b10; fill = 2'b00; sin_left = 1'b1; step();
    check("shl_serial", {24'd0, q}, 32'h2D);
    sel = 2'b01; fill = 2'b10; step();
    check("shr_arith_pos", {24'd0, q}, 32'h16);
    check("direct_done", {31'd0, done}, 32'd0);

    // Sequenced arithmetic right by 3 from 0x80; sel=11 during SHIFT is ignored
    sel = 2'b11; par_in = 8'h80; step();
    exp_q = '{8'h80, 8'hC0, 8'hE0, 8'hF0};
    sel = 2'b01; fill = 2'b10; amount = 4'd3; start = 1'b1; step();
    check_seq_q("seq3_start_q");
    check("seq3_start_busy", {31'd0, busy}, 32'd1);
    check("seq3_start_state", {31'd0, state_dbg}, 32'd1);
    start = 1'b0; sel = 2'b11; par_in = 8'hFF; fill = 2'b00; amount = 4'd7;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) sel = 2'b11;
      step();
      check_seq_q("seq3_q");
      check("seq3_busy", {31'd0, busy}, (i < 2) ? 32'd1 : 32'd0);
      check("seq3_done", {31'd0, done}, (i == 2) ? 32'd1 : 32'd0);
      if (i == 2) sel = 2'b00;
    end
    step();
    check("seq3_done_pulse", {31'd0, done}, 32'd0);
    check("seq3_hold_q", {24'd0, q}, 32'hF0);

    // Rotate left by WIDTH returns the original value, done after edge 9
    sel = 2'b11; par_in = 8'h3C; step();
    exp_q = '{8'h78, 8'hF0, 8'hE1, 8'hC3, 8'h87, 8'h0F, 8'h1E, 8'h3C};
    sel = 2'b10; fill = 2'b01; amount = 4'd8; start = 1'b1; step();
    check("rot8_start_q", {24'd0, q}, 32'h3C);
    start = 1'b0; sel = 2'b00;
    for (int i = 0; i < 8; i++) begin
      sin_right = 1'($urandom_range(0, 1));
      sin_left  = 1'($urandom_range(0, 1));
      step();
      check_seq_q("rot8_q");
      check("rot8_done", {31'd0, done}, (i == 7) ? 32'd1 : 32'd0);
      check("rot8_busy", {31'd0, busy}, (i < 7) ? 32'd1 : 32'd0);
    end

    // amount=0: done next cycle, no busy; start in done cycle is accepted
    sel = 2'b01; fill = 2'b00; amount = 4'd0; start = 1'b1; step();
    check("amt0_q", {24'd0, q}, 32'h3C);
    check("amt0_busy", {31'd0, busy}, 32'd0);
    check("amt0_done", {31'd0, done}, 32'd1);
    fill = 2'b11; amount = 4'd1; step();
    check("done_cycle_start_busy", {31'd0, busy}, 32'd1);
    check("done_cycle_start_done", {31'd0, done}, 32'd0);
    check("done_cycle_start_q", {24'd0, q}, 32'h3C);
    start = 1'b0; sel = 2'b00; step();
    check("amt1_q", {24'd0, q}, 32'h1E);
    check("amt1_done", {31'd0, done}, 32'd1);
    check("amt1_busy", {31'd0, busy}, 32'd0);
    step();
    check("amt1_done_low", {31'd0, done}, 32'd0);

    // start with sel=11 is a plain load
    sel = 2'b11; par_in = 8'h5A; start = 1'b1; amount = 4'd2; step();
    check("start_load_q", {24'd0, q}, 32'h5A);
    check("start_load_busy", {31'd0, busy}, 32'd0);
    start = 1'b0; sel = 2'b00; step();
    check("start_load_done", {31'd0, done}, 32'd0);

    // Async clear in the middle of a sequence
    sel = 2'b11; par_in = 8'hA5; step();
    sel = 2'b01; fill = 2'b00; sin_right = 1'b0; amount = 4'd3; start = 1'b1; step();
    start = 1'b0; sel = 2'b00;
    check("clr_pre_busy", {31'd0, busy}, 32'd1);
    check("clr_pre_q", {24'd0, q}, 32'hA5);
    #2 clear = 1'b0;
    #1;
    check("clr_q", {24'd0, q}, 32'h00);
    check("clr_busy", {31'd0, busy}, 32'd0);
    check("clr_done", {31'd0, done}, 32'd0);
    #2 clear = 1'b1;
    step();
    check("clr_after_q", {24'd0, q}, 32'h00);
    check("clr_after_busy", {31'd0, busy}, 32'd0);
    check("clr_after_done", {31'd0, done}, 32'd0);

`ifdef USR_SEQ_CARRY_EN
    sel = 2'b11; par_in = 8'h81; step();
    sel = 2'b01; fill = 2'b11; step();
    check("carry_shr_q", {24'd0, q}, 32'h40);
    check("carry_shr", {31'd0, carry}, 32'd1);
    sel = 2'b00; step();
    check("carry_hold", {31'd0, carry}, 32'd1);
    sel = 2'b10; fill = 2'b11; step();
    check("carry_shl_q", {24'd0, q}, 32'h80);
    check("carry_shl", {31'd0, carry}, 32'd0);
    sel = 2'b01; fill = 2'b11; amount = 4'd1; start = 1'b1; step();
    start = 1'b0; sel = 2'b00; step();
    check("carry_seq_q", {24'd0, q}, 32'h40);
    check("carry_seq", {31'd0, carry}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
